core_mem_access_ctrl: RTL and testbench
=======================================

// Module: core_mem_access_ctrl
// PURPOSE
// - Sequences execute-stage load/store requests onto one shared single-port data bus (req/ack).
// - Stalls the pipeline until each access completes.
// - Generates byte enables and replicated write data; right-aligns read data so the
//   execute stage sign/zero-extends from bit 0.
// - Sits between the execute stage, the core controller (stall) and the system bus.
// PARAMETERS
// - TIMEOUT_CYCLES  255  wait cycles without bus_ack before the access is aborted as a fault (1..255)
// PORTS
// - clk           in   1   core clock
// - rst_n         in   1   synchronous reset, active low
// - ld_req        in   1   load access requested by execute stage (level, held while stall=1)
// - ld_addr       in   32  load byte address
// - ld_data       out  32  read data shifted right by 8*ld_addr[1:0]; valid while state=DONE
// - st_req        in   1   store access requested (level, held while stall=1)
// - st_addr       in   32  store byte address
// - st_data       in   32  store data, LSB-aligned
// - st_width      in   2   0=byte 1=half 2=word (funct3[1:0])
// - stall         out  1   freeze IF/ID/EX; combinational
// - access_fault  out  1   one-cycle pulse: bus_err or timeout
// - bus_req       out  1   bus request, registered
// - bus_we        out  1   1=write, registered
// - bus_addr      out  32  word address {addr[31:2],2'b00}, registered
// - bus_wdata     out  32  replicated write data, registered
// - bus_be        out  4   byte enables, registered
// - bus_ack       in   1   access complete this cycle
// - bus_err       in   1   qualifies bus_ack: access failed
// - bus_rdata     in   32  read data, valid with bus_ack
// BEHAVIOUR
// - Reset values: bus_req=0 bus_we=0 bus_addr=0 bus_wdata=0 bus_be=0 ld_data=0
//   access_fault=0; state=IDLE; timeout counter=0.
// - States: IDLE, STORE, LOAD, DONE.
// - IDLE:
//   - st_req -> STORE;
//   - else ld_req -> LOAD;
//   - bus_* registered on the same edge, so bus_req rises 1 cycle after the request.
// - STORE/LOAD:
//   - Hold bus_req and all bus_* stable until bus_ack.
//   - On ack in STORE with ld_req=1 -> LOAD (bus_req stays 1, bus_we=0, new addr/be),
//     i.e. store always precedes load.
//   - Otherwise on ack -> DONE and drop bus_req.
//   - LOAD ack captures ld_data.
// - DONE: exactly one cycle, then -> IDLE; EX retires the instruction this cycle.
// - stall = (ld_req|st_req) & (state!=DONE).
//   - Minimum latency with zero-wait ack: 3 cycles (IDLE, ACCESS, DONE).
// - Byte enables, shift s=addr[1:0]:
//   - width0 = 4'b0001<<s; width1 = 4'b0011<<s; width2 = 4'b1111.
//   - Truncate to 4 bits; width3 treated as word.
// - Write data: width0 = {4{st_data[7:0]}}; width1 = {2{st_data[15:0]}}; width2 = st_data.
// - Read data: ld_data = bus_rdata >> (8*ld_addr[1:0]); upper bits zero.
// - Timeout:
//   - Counter clears on entering STORE/LOAD; increments each cycle without ack.
//   - Reaching TIMEOUT_CYCLES: drop bus_req, pulse access_fault, ld_data=0, -> DONE
//     (pending load skipped).
// - bus_ack & bus_err: same as timeout (fault, ld_data=0, -> DONE, pending load skipped).
// - bus_ack outside STORE/LOAD is ignored.
// - Requests deasserted mid-access (flush): the access still completes;
//   DONE then drops stall.
// - rst_n low mid-access: all outputs take reset values at that edge;
//   no ack is awaited afterwards.
// CONFIGURATION
// - CORE_MISALIGN_TRAP_EN defined:
//   - Half access with addr[0]=1, or word access with addr[1:0]!=0, issues no bus cycle.
//   - IDLE -> DONE directly, pulsing misalign_ld or misalign_st (extra out, 1 bit each,
//     reset 0) in DONE.
//   - Store misaligned with a load pending: both flagged, neither issued.
// - Undefined:
//   - Ports absent; misaligned accesses are issued.
//   - Byte enables truncated to the word (bytes past lane 3 dropped).
// TESTING
// - SW 0x1000 data 0xDEADBEEF, ack 2 cycles later:
//   bus_we=1 be=F wdata=DEADBEEF; stall high 4 cycles, low in DONE.
// - SB addr 0x1003 data 0x5A:
//   be=4'b1000, wdata=0x5A5A5A5A, bus_addr=0x1000.
// - LH addr 0x2002, rdata 0xBEEF1234:
//   be=4'b1100, ld_data=0x0000BEEF in DONE.
// - st_req+ld_req same cycle:
//   store cycle then load cycle back-to-back with bus_req continuously high; single DONE.
// - No ack, TIMEOUT_CYCLES=4:
//   bus_req drops after 4 wait cycles, access_fault 1-cycle pulse, ld_data=0.
//   Repeat with bus_ack+bus_err -> same response.
// - LW addr 0x3001, with CORE_MISALIGN_TRAP_EN: no bus_req, misalign_ld pulse.
//   Without the macro: bus_addr=0x3000 be=4'b1110.
//   rst_n low mid-access: bus_req=0 next edge.

Source files
------------

// File: rtl/core_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// core_mem_access_ctrl
//
// Purpose:
//   Sequences execute-stage load/store requests onto a single shared req/ack
//   data bus and stalls the pipeline until each access completes. It builds
//   byte enables and lane-replicated write data for stores. Read data is
//   shifted right by the byte offset so the execute stage can extend it from
//   bit 0. When a load and a store are requested together, the store runs
//   first and the load follows back-to-back.
//
//   The access width (st_width, funct3[1:0] of the instruction) applies to
//   loads as well as stores: 0=byte, 1=half, 2/3=word.
//
// Configuration:
//   CORE_MISALIGN_TRAP_EN - when defined, misaligned half/word accesses issue
//   no bus cycle and are reported on misalign_ld / misalign_st instead.
//   When undefined those ports are absent. Misaligned accesses are then
//   issued, and byte enables that fall past lane 3 are dropped.
//
// Ports:
//   clk, rst_n        core clock, synchronous active-low reset
//   ld_req/ld_addr    load request (level) and byte address
//   ld_data           aligned read data, valid while the access is in DONE
//   st_req/st_addr    store request (level) and byte address
//   st_data/st_width  LSB-aligned store data and access width
//   stall             combinational pipeline freeze
//   access_fault      one-cycle pulse on bus error or timeout
//   misalign_ld/_st   one-cycle misalignment pulses (CORE_MISALIGN_TRAP_EN only)
//   bus_*             registered bus request side; bus_ack/err/rdata responses
// -----------------------------------------------------------------------------
module core_mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   output logic [31:0] ld_data,
   input  logic        st_req,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [1:0]  st_width,
   output logic        stall,
   output logic        access_fault,
`ifdef CORE_MISALIGN_TRAP_EN
   output logic        misalign_ld,
   output logic        misalign_st,
`endif
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STORE = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Counter value on which a still-unacknowledged access gets aborted.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

   state_t      state_r;
   logic [7:0]  wait_cnt_r;

   logic [3:0]  st_be_s;
   logic [3:0]  ld_be_s;
   logic [31:0] st_wdata_s;
   logic [31:0] ld_aligned_s;
   logic        st_trap_s;
   logic        ld_trap_s;

   // Lane mask for an access; the 4-bit result drops lanes shifted past byte 3.
   function automatic logic [3:0] calc_be(input logic [1:0] width, input logic [1:0] shift);
      logic [3:0] base_v;
      case (width)
         2'd0:    base_v = 4'b0001;
         2'd1:    base_v = 4'b0011;
         default: base_v = 4'b1111;
      endcase
      calc_be = base_v << shift;
   endfunction

   // Replicate the store data so the addressed lanes carry it whatever the offset.
   function automatic logic [31:0] calc_wdata(input logic [1:0] width, input logic [31:0] data);
      case (width)
         2'd0:    calc_wdata = {4{data[7:0]}};
         2'd1:    calc_wdata = {2{data[15:0]}};
         default: calc_wdata = data;
      endcase
   endfunction

`ifdef CORE_MISALIGN_TRAP_EN
   // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] shift);
      case (width)
         2'd0:    is_misaligned = 1'b0;
         2'd1:    is_misaligned = shift[0];
         default: is_misaligned = (shift != 2'b00);
      endcase
   endfunction

   assign st_trap_s = is_misaligned(st_width, st_addr[1:0]);
   assign ld_trap_s = is_misaligned(st_width, ld_addr[1:0]);
`else
   assign st_trap_s = 1'b0;
   assign ld_trap_s = 1'b0;
`endif

   assign st_be_s      = calc_be(st_width, st_addr[1:0]);
   assign ld_be_s      = calc_be(st_width, ld_addr[1:0]);
   assign st_wdata_s   = calc_wdata(st_width, st_data);
   assign ld_aligned_s = bus_rdata >> {ld_addr[1:0], 3'b000};

   // DONE is the retire cycle, so the freeze lifts there even with requests held.
   assign stall = (ld_req | st_req) & (state_r != ST_DONE);

   // Access sequencer: state, registered bus request fields, read capture, fault pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         wait_cnt_r   <= 8'd0;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= 32'd0;
         bus_wdata    <= 32'd0;
         bus_be       <= 4'd0;
         ld_data      <= 32'd0;
         access_fault <= 1'b0;
`ifdef CORE_MISALIGN_TRAP_EN
         misalign_ld  <= 1'b0;
         misalign_st  <= 1'b0;
`endif
      end else begin
         access_fault <= 1'b0;
`ifdef CORE_MISALIGN_TRAP_EN
         misalign_ld  <= 1'b0;
         misalign_st  <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
               if (st_req && st_trap_s) begin
                  // A trapped store also suppresses any load of the same instruction.
                  state_r <= ST_DONE;
`ifdef CORE_MISALIGN_TRAP_EN
                  misalign_st <= 1'b1;
                  misalign_ld <= ld_req;
`endif
               end else if (st_req) begin
                  state_r    <= ST_STORE;
                  wait_cnt_r <= 8'd0;
                  bus_req    <= 1'b1;
                  bus_we     <= 1'b1;
                  bus_addr   <= {st_addr[31:2], 2'b00};
                  bus_wdata  <= st_wdata_s;
                  bus_be     <= st_be_s;
               end else if (ld_req && ld_trap_s) begin
                  state_r <= ST_DONE;
`ifdef CORE_MISALIGN_TRAP_EN
                  misalign_ld <= 1'b1;
`endif
               end else if (ld_req) begin
                  state_r    <= ST_LOAD;
                  wait_cnt_r <= 8'd0;
                  bus_req    <= 1'b1;
                  bus_we     <= 1'b0;
                  bus_addr   <= {ld_addr[31:2], 2'b00};
                  bus_be     <= ld_be_s;
               end else begin
                  state_r <= ST_IDLE;
               end
            end

            ST_STORE, ST_LOAD: begin
               if (bus_ack && bus_err) begin
                  // Failed access: abort, skip any pending load.
                  state_r      <= ST_DONE;
                  bus_req      <= 1'b0;
                  access_fault <= 1'b1;
                  ld_data      <= 32'd0;
               end else if (bus_ack && (state_r == ST_STORE) && ld_req && !ld_trap_s) begin
                  // Chain the pending load without dropping bus_req.
                  state_r    <= ST_LOAD;
                  wait_cnt_r <= 8'd0;
                  bus_we     <= 1'b0;
                  bus_addr   <= {ld_addr[31:2], 2'b00};
                  bus_be     <= ld_be_s;
               end else if (bus_ack && (state_r == ST_STORE) && ld_req) begin
                  state_r <= ST_DONE;
                  bus_req <= 1'b0;
`ifdef CORE_MISALIGN_TRAP_EN
                  misalign_ld <= 1'b1;
`endif
               end else if (bus_ack) begin
                  state_r <= ST_DONE;
                  bus_req <= 1'b0;
                  if (state_r == ST_LOAD) begin
                     ld_data <= ld_aligned_s;
                  end else begin
                     ld_data <= ld_data;
                  end
               end else if (wait_cnt_r >= TIMEOUT_LAST) begin
                  state_r      <= ST_DONE;
                  bus_req      <= 1'b0;
                  access_fault <= 1'b1;
                  ld_data      <= 32'd0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end

            ST_DONE: begin
               state_r <= ST_IDLE;
            end

            default: begin
               state_r <= ST_IDLE;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_mem_access_ctrl
//
// Directed bench for core_mem_access_ctrl with TIMEOUT_CYCLES=4. Expected bus
// transactions are queued when a request is driven and popped when bus_req
// is seen. Inputs change and outputs are sampled just after the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_core_mem_access_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        st_req;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_width;
   logic        stall;
   logic        access_fault;
`ifdef CORE_MISALIGN_TRAP_EN
   logic        misalign_ld;
   logic        misalign_st;
`endif
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   core_mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ld_req       (ld_req),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .st_req       (st_req),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .st_width     (st_width),
      .stall        (stall),
      .access_fault (access_fault),
`ifdef CORE_MISALIGN_TRAP_EN
      .misalign_ld  (misalign_ld),
      .misalign_st  (misalign_st),
`endif
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_be       (bus_be),
      .bus_ack      (bus_ack),
      .bus_err      (bus_err),
      .bus_rdata    (bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } txn_t;

   txn_t sb_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata);
      txn_t t;
      t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
      sb_q.push_back(t);
   endtask

   task automatic expect_txn(input string tag);
      txn_t e;
      check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "_req"},  32'(bus_req), 32'd1);
         check({tag, "_we"},   32'(bus_we),  32'(e.we));
         check({tag, "_addr"}, bus_addr,     e.addr);
         check({tag, "_be"},   32'(bus_be),  32'(e.be));
         if (e.we) check({tag, "_wdata"}, bus_wdata, e.wdata);
      end
   endtask

   // Wait (bounded) for bus_req, compare against the queue, insert wait
   // cycles, then acknowledge. Returns at the falling edge after the ack edge.
   task automatic bus_cycle(input string tag, input int waits, input logic err,
                            input logic [31:0] rdata, input logic exp_stall);
      int n = 0;
      while (bus_req !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      expect_txn(tag);
      for (int i = 0; i < waits; i++) begin
         check({tag, "_stall_wait"}, 32'(stall), 32'(exp_stall));
         @(negedge clk);
         check({tag, "_req_held"}, 32'(bus_req), 32'd1);
      end
      check({tag, "_stall_ack"}, 32'(stall), 32'(exp_stall));
      bus_ack = 1'b1; bus_err = err; bus_rdata = rdata;
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
   endtask

   task automatic drive(input logic st, input logic ld, input logic [31:0] saddr,
                        input logic [31:0] sdata, input logic [1:0] w, input logic [31:0] laddr);
      st_req = st; ld_req = ld; st_addr = saddr; st_data = sdata; st_width = w; ld_addr = laddr;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_bus_req",   32'(bus_req), 32'd0);
      check("rst_bus_we",    32'(bus_we), 32'd0);
      check("rst_bus_addr",  bus_addr, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_bus_be",    32'(bus_be), 32'd0);
      check("rst_ld_data",   ld_data, 32'd0);
      check("rst_fault",     32'(access_fault), 32'd0);
      check("rst_stall",     32'(stall), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ack while idle is ignored
      bus_ack = 1'b1; bus_err = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0;
      check("idle_ack_req",   32'(bus_req), 32'd0);
      check("idle_ack_fault", 32'(access_fault), 32'd0);

      // SW 0x1000 0xDEADBEEF, two wait cycles: stall high for 4 cycles
      drive(1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 2'd2, 32'd0);
      push_txn(1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
      #1 check("sw_stall_idle", 32'(stall), 32'd1);
      @(negedge clk);
      bus_cycle("sw", 2, 1'b0, 32'd0, 1'b1);
      check("sw_done_stall", 32'(stall), 32'd0);
      check("sw_done_req",   32'(bus_req), 32'd0);
      check("sw_done_fault", 32'(access_fault), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);

      // SB 0x1003 0x5A
      drive(1'b1, 1'b0, 32'h0000_1003, 32'h0000_005A, 2'd0, 32'd0);
      push_txn(1'b1, 32'h0000_1000, 4'b1000, 32'h5A5A_5A5A);
      @(negedge clk);
      bus_cycle("sb", 0, 1'b0, 32'd0, 1'b1);
      check("sb_done_stall", 32'(stall), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);

      // LH 0x2002, rdata 0xBEEF1234
      drive(1'b0, 1'b1, 32'd0, 32'd0, 2'd1, 32'h0000_2002);
      push_txn(1'b0, 32'h0000_2000, 4'b1100, 32'd0);
      @(negedge clk);
      bus_cycle("lh", 1, 1'b0, 32'hBEEF_1234, 1'b1);
      check("lh_ld_data", ld_data, 32'h0000_BEEF);
      check("lh_stall",   32'(stall), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);

      // LB 0x6001 answered with bus_err
      drive(1'b0, 1'b1, 32'd0, 32'd0, 2'd0, 32'h0000_6001);
      push_txn(1'b0, 32'h0000_6000, 4'b0010, 32'd0);
      @(negedge clk);
      bus_cycle("lerr", 0, 1'b1, 32'hFFFF_FFFF, 1'b1);
      check("lerr_fault",   32'(access_fault), 32'd1);
      check("lerr_ld_data", ld_data, 32'd0);
      check("lerr_req",     32'(bus_req), 32'd0);
      check("lerr_stall",   32'(stall), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);
      check("lerr_pulse_end", 32'(access_fault), 32'd0);

      // Store + load together: back-to-back, bus_req held, single DONE
      drive(1'b1, 1'b1, 32'h0000_4000, 32'h1122_3344, 2'd2, 32'h0000_4004);
      push_txn(1'b1, 32'h0000_4000, 4'hF, 32'h1122_3344);
      push_txn(1'b0, 32'h0000_4004, 4'hF, 32'd0);
      @(negedge clk);
      bus_cycle("b2b_st", 0, 1'b0, 32'd0, 1'b1);
      check("b2b_stall_between", 32'(stall), 32'd1);
      bus_cycle("b2b_ld", 1, 1'b0, 32'hCAFE_F00D, 1'b1);
      check("b2b_ld_data", ld_data, 32'hCAFE_F00D);
      check("b2b_stall",   32'(stall), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);
      check("b2b_idle_req", 32'(bus_req), 32'd0);

      // Timeout: LW 0x5000 never acknowledged
      drive(1'b0, 1'b1, 32'd0, 32'd0, 2'd2, 32'h0000_5000);
      push_txn(1'b0, 32'h0000_5000, 4'hF, 32'd0);
      @(negedge clk);
      expect_txn("to");
      n = 0;
      while (bus_req === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("to_req_cycles", 32'(n), 32'(TO));
      check("to_fault",      32'(access_fault), 32'd1);
      check("to_ld_data",    ld_data, 32'd0);
      check("to_stall",      32'(stall), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);
      check("to_pulse_end", 32'(access_fault), 32'd0);

      // Store fails with a load pending: load skipped
      drive(1'b1, 1'b1, 32'h0000_4100, 32'h0000_0055, 2'd2, 32'h0000_4104);
      push_txn(1'b1, 32'h0000_4100, 4'hF, 32'h0000_0055);
      @(negedge clk);
      bus_cycle("serr", 0, 1'b1, 32'd0, 1'b1);
      check("serr_load_skipped", 32'(bus_req), 32'd0);
      check("serr_fault",        32'(access_fault), 32'd1);
      check("serr_stall",        32'(stall), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);
      check("serr_idle_req", 32'(bus_req), 32'd0);

      // Flush: LB 0x7003, request dropped mid-access, access still completes
      drive(1'b0, 1'b1, 32'd0, 32'd0, 2'd0, 32'h0000_7003);
      push_txn(1'b0, 32'h0000_7000, 4'b1000, 32'd0);
      @(negedge clk);
      expect_txn("fl");
      ld_req = 1'b0;
      #1 check("fl_stall_drop", 32'(stall), 32'd0);
      @(negedge clk);
      check("fl_req_held", 32'(bus_req), 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'hAB00_0000;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'd0;
      check("fl_ld_data", ld_data, 32'h0000_00AB);
      check("fl_req_done", 32'(bus_req), 32'd0);
      @(negedge clk);

      // LW 0x3001 misaligned
      drive(1'b0, 1'b1, 32'd0, 32'd0, 2'd2, 32'h0000_3001);
`ifdef CORE_MISALIGN_TRAP_EN
      @(negedge clk);
      check("lwmis_no_req", 32'(bus_req), 32'd0);
      check("lwmis_flag",   32'(misalign_ld), 32'd1);
      check("lwmis_st_flag", 32'(misalign_st), 32'd0);
      check("lwmis_stall",  32'(stall), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);
      check("lwmis_pulse_end", 32'(misalign_ld), 32'd0);
      // Misaligned store with a load pending: both flagged, nothing issued
      drive(1'b1, 1'b1, 32'h0000_3102, 32'd0, 2'd2, 32'h0000_3200);
      @(negedge clk);
      check("smis_no_req",  32'(bus_req), 32'd0);
      check("smis_st_flag", 32'(misalign_st), 32'd1);
      check("smis_ld_flag", 32'(misalign_ld), 32'd1);
`else
      push_txn(1'b0, 32'h0000_3000, 4'b1110, 32'd0);
      @(negedge clk);
      bus_cycle("lwmis", 0, 1'b0, 32'h4433_2211, 1'b1);
      check("lwmis_ld_data", ld_data, 32'h0044_3322);
`endif
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);

      // Reset asserted mid-access
      drive(1'b1, 1'b0, 32'h0000_8000, 32'h1234_5678, 2'd2, 32'd0);
      push_txn(1'b1, 32'h0000_8000, 4'hF, 32'h1234_5678);
      @(negedge clk);
      expect_txn("rst_mid");
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid_req",     32'(bus_req), 32'd0);
      check("rstmid_be",      32'(bus_be), 32'd0);
      check("rstmid_addr",    bus_addr, 32'd0);
      check("rstmid_wdata",   bus_wdata, 32'd0);
      check("rstmid_ld_data", ld_data, 32'd0);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      repeat (2) @(negedge clk);
      check("rstmid_no_reissue", 32'(bus_req), 32'd0);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
